// File: rtl/scie_cfir_pkg.sv
// Shared definitions for the SCIE complex FIR MAC: opcodes, FSM states,
// accumulator sizing and a complex operand type.
package scie_cfir_pkg;

    localparam logic [6:0] OP_LOADC   = 7'h0B;
    localparam logic [6:0] OP_PUSH    = 7'h2B;
    localparam logic [6:0] OP_COMPUTE = 7'h5B;
    localparam logic [6:0] OP_CLEAR   = 7'h7B;

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    // Guard bits cover NTAPS full-scale products plus the complex add/sub growth.
    function automatic int acc_width(input int dw, input int ntaps);
        return 2 * dw + $clog2(ntaps) + 1;
    endfunction

    localparam int CPLX_W = 64;

    typedef struct packed {
        logic signed [CPLX_W-1:0] re;
        logic signed [CPLX_W-1:0] im;
    } cplx_t;

endpackage

// File: rtl/scie_cfir_mac_cmul.sv
// Combinational signed complex multiplier: DW-bit operands, full 2*DW-bit products.
module scie_cmul #(
    parameter int DW = 64
) (
    input  logic signed [DW-1:0]   a_re,
    input  logic signed [DW-1:0]   a_im,
    input  logic signed [DW-1:0]   b_re,
    input  logic signed [DW-1:0]   b_im,
    output logic signed [2*DW-1:0] p_re,
    output logic signed [2*DW-1:0] p_im
);

    logic signed [2*DW-1:0] rr, ii, ri, ir;

    assign rr = (2*DW)'(a_re) * (2*DW)'(b_re);
    assign ii = (2*DW)'(a_im) * (2*DW)'(b_im);
    assign ri = (2*DW)'(a_re) * (2*DW)'(b_im);
    assign ir = (2*DW)'(a_im) * (2*DW)'(b_re);

    assign p_re = rr - ii;
    assign p_im = ri + ir;

endmodule

// File: rtl/scie_cfir_mac.sv
// Sequential complex FIR MAC behind the SCIE port; one shared complex multiplier.
// Optional clamping of the result is enabled by defining SCIE_CFIR_SAT_EN.
module scie_cfir_mac
    import scie_cfir_pkg::*;
#(
    parameter int NTAPS = 5,
    parameter int DW    = 64,
    parameter int FRAC  = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 io_valid,
    output logic                 io_ready,
    input  logic [31:0]          io_insn,
    input  logic signed [DW-1:0] io_rs1_real,
    input  logic signed [DW-1:0] io_rs1_imag,
    input  logic [31:0]          io_rs2,
    output logic                 io_rd_valid,
    output logic signed [DW-1:0] io_rd_real,
    output logic signed [DW-1:0] io_rd_imag
);

    localparam int              ACC_W  = acc_width(DW, NTAPS);
    localparam int              KW     = $clog2(NTAPS);
    localparam logic [KW-1:0]   K_LAST = KW'(NTAPS - 1);

`ifdef SCIE_CFIR_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'({1'b0, {(DW-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
`endif

    state_t                 state;
    logic                   ready_r;
    logic [KW-1:0]          k;
    logic signed [DW-1:0]   coef_re [NTAPS];
    logic signed [DW-1:0]   coef_im [NTAPS];
    logic signed [DW-1:0]   x_re    [NTAPS];
    logic signed [DW-1:0]   x_im    [NTAPS];
    logic signed [ACC_W-1:0] acc_re, acc_im;
    logic signed [2*DW-1:0] prod_re, prod_im;
    logic                   rd_valid_r;
    logic signed [DW-1:0]   rd_re_r, rd_im_r;
    logic                   unused_insn;

    assign unused_insn = ^io_insn[31:7];

    scie_cmul #(.DW(DW)) u_cmul (
        .a_re (coef_re[k]),
        .a_im (coef_im[k]),
        .b_re (x_re[k]),
        .b_im (x_im[k]),
        .p_re (prod_re),
        .p_im (prod_im)
    );

    // Floor shift of the accumulator, then either clamp or two's-complement wrap.
    function automatic logic signed [DW-1:0] scale(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] s;
        s = v >>> FRAC;
`ifdef SCIE_CFIR_SAT_EN
        if (s > SAT_MAX)
            s = SAT_MAX;
        else if (s < SAT_MIN)
            s = SAT_MIN;
`endif
        return s[DW-1:0];
    endfunction

    assign io_ready    = ready_r;
    assign io_rd_valid = rd_valid_r;
    assign io_rd_real  = rd_re_r;
    assign io_rd_imag  = rd_im_r;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ready_r    <= 1'b1;
            k          <= '0;
            acc_re     <= '0;
            acc_im     <= '0;
            rd_valid_r <= 1'b0;
            rd_re_r    <= '0;
            rd_im_r    <= '0;
            for (int i = 0; i < NTAPS; i++) begin
                coef_re[i] <= '0;
                coef_im[i] <= '0;
                x_re[i]    <= '0;
                x_im[i]    <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (io_valid && ready_r) begin
                        case (io_insn[6:0])
                            OP_LOADC: begin
                                if (io_rs2 < 32'(NTAPS)) begin
                                    coef_re[io_rs2[KW-1:0]] <= io_rs1_real;
                                    coef_im[io_rs2[KW-1:0]] <= io_rs1_imag;
                                end
                            end
                            OP_PUSH: begin
                                for (int i = NTAPS - 1; i > 0; i--) begin
                                    x_re[i] <= x_re[i-1];
                                    x_im[i] <= x_im[i-1];
                                end
                                x_re[0] <= io_rs1_real;
                                x_im[0] <= io_rs1_imag;
                            end
                            OP_COMPUTE: begin
                                acc_re     <= '0;
                                acc_im     <= '0;
                                rd_valid_r <= 1'b0;
                                k          <= '0;
                                ready_r    <= 1'b0;
                                state      <= MAC;
                            end
                            OP_CLEAR: begin
                                for (int i = 0; i < NTAPS; i++) begin
                                    x_re[i] <= '0;
                                    x_im[i] <= '0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                MAC: begin
                    acc_re <= acc_re + ACC_W'(prod_re);
                    acc_im <= acc_im + ACC_W'(prod_im);
                    if (k == K_LAST)
                        state <= DONE;
                    else
                        k <= k + 1'b1;
                end
                DONE: begin
                    rd_re_r    <= scale(acc_re);
                    rd_im_r    <= scale(acc_im);
                    rd_valid_r <= 1'b1;
                    ready_r    <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scie_cfir_mac.sv
// Directed bench for scie_cfir_mac: 64-bit default instance plus a 16-bit, FRAC=0 instance.
module tb_scie_cfir_mac;

    localparam logic [6:0] T_LOADC   = 7'h0B;
    localparam logic [6:0] T_PUSH    = 7'h2B;
    localparam logic [6:0] T_COMPUTE = 7'h5B;
    localparam logic [6:0] T_CLEAR   = 7'h7B;

    logic               clock = 1'b0;
    logic               reset;
    logic               io_valid;
    logic               io_ready;
    logic [31:0]        io_insn;
    logic signed [63:0] io_rs1_real, io_rs1_imag;
    logic [31:0]        io_rs2;
    logic               io_rd_valid;
    logic signed [63:0] io_rd_real, io_rd_imag;

    logic               v16;
    logic               rdy16;
    logic [31:0]        insn16;
    logic signed [15:0] rs1r16, rs1i16;
    logic [31:0]        rs2_16;
    logic               rdv16;
    logic signed [15:0] rdr16, rdi16;

    int ncmp = 0;
    int nfail = 0;

    logic signed [63:0] mc_re [5];
    logic signed [63:0] mc_im [5];
    logic signed [63:0] mx_re [5];
    logic signed [63:0] mx_im [5];

    always #5 clock = ~clock;

    scie_cfir_mac u_dut (
        .clock       (clock),
        .reset       (reset),
        .io_valid    (io_valid),
        .io_ready    (io_ready),
        .io_insn     (io_insn),
        .io_rs1_real (io_rs1_real),
        .io_rs1_imag (io_rs1_imag),
        .io_rs2      (io_rs2),
        .io_rd_valid (io_rd_valid),
        .io_rd_real  (io_rd_real),
        .io_rd_imag  (io_rd_imag)
    );

    scie_cfir_mac #(.NTAPS(5), .DW(16), .FRAC(0)) u_dut16 (
        .clock       (clock),
        .reset       (reset),
        .io_valid    (v16),
        .io_ready    (rdy16),
        .io_insn     (insn16),
        .io_rs1_real (rs1r16),
        .io_rs1_imag (rs1i16),
        .io_rs2      (rs2_16),
        .io_rd_valid (rdv16),
        .io_rd_real  (rdr16),
        .io_rd_imag  (rdi16)
    );

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear_all();
        for (int t = 0; t < 5; t++) begin
            mc_re[t] = '0; mc_im[t] = '0; mx_re[t] = '0; mx_im[t] = '0;
        end
    endtask

    task automatic model_result(output logic signed [63:0] yr, output logic signed [63:0] yi);
        logic signed [139:0] sr, si, ar, ai, br, bi;
        sr = '0;
        si = '0;
        for (int t = 0; t < 5; t++) begin
            ar = 140'(mc_re[t]); ai = 140'(mc_im[t]);
            br = 140'(mx_re[t]); bi = 140'(mx_im[t]);
            sr = sr + ar * br - ai * bi;
            si = si + ar * bi + ai * br;
        end
        sr = sr >>> 8;
        si = si >>> 8;
        yr = sr[63:0];
        yi = si[63:0];
    endtask

    // Holds the command until accepted; reports how many sampled cycles io_ready was low.
    task automatic issue(input logic [6:0] op, input logic signed [63:0] re, input logic signed [63:0] im,
                         input logic [31:0] idx, output int waited);
        waited = 0;
        io_valid = 1'b1; io_insn = {25'd0, op};
        io_rs1_real = re; io_rs1_imag = im; io_rs2 = idx;
        while (!io_ready && waited < 50) begin
            @(posedge clock); #1;
            waited++;
        end
        if (!io_ready) begin
            ncmp++; nfail++;
            $error("FAIL accept_timeout: observed ready %0d expected 1", io_ready);
            io_valid = 1'b0;
            return;
        end
        @(posedge clock); #1;
        io_valid = 1'b0;
        case (op)
            T_LOADC: if (idx < 5) begin mc_re[idx] = re; mc_im[idx] = im; end
            T_PUSH: begin
                for (int t = 4; t > 0; t--) begin mx_re[t] = mx_re[t-1]; mx_im[t] = mx_im[t-1]; end
                mx_re[0] = re; mx_im[0] = im;
            end
            T_CLEAR: for (int t = 0; t < 5; t++) begin mx_re[t] = '0; mx_im[t] = '0; end
            default: ;
        endcase
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(posedge clock); #1;
            n++;
        end while (!io_rd_valid && n < 30);
    endtask

    initial begin
        int w, n;
        logic signed [63:0] er, ei;
        logic signed [63:0] exp16;

        reset = 1'b1; io_valid = 1'b0; io_insn = '0; io_rs1_real = '0; io_rs1_imag = '0; io_rs2 = '0;
        v16 = 1'b0; insn16 = '0; rs1r16 = '0; rs1i16 = '0; rs2_16 = '0;
        model_clear_all();
        repeat (2) @(posedge clock);
        #1;
        check("reset_ready", 64'(io_ready), 64'd1);
        check("reset_rd_valid", 64'(io_rd_valid), 64'd0);
        check("reset_rd_real", io_rd_real, 64'sd0);
        check("reset_rd_imag", io_rd_imag, 64'sd0);
        reset = 1'b0;

        // Single tap, single sample; floor shift on the negative imaginary part.
        issue(T_LOADC, 64'sd9007, -64'sd728, 32'd0, w);
        issue(T_PUSH, 64'sd9431, -64'sd4819, 32'd0, w);
        issue(T_COMPUTE, 64'sd0, 64'sd0, 32'd0, w);
        wait_valid(n);
        check("latency", 64'(n), 64'd6);
        check("basic_real", io_rd_real, 64'sd318112);
        check("basic_imag", io_rd_imag, -64'sd196370);

        // All five taps populated, then a PUSH held off while the MAC runs.
        issue(T_LOADC, -64'sd1500, 64'sd2000, 32'd1, w);
        issue(T_LOADC, 64'sd123456789, -64'sd987654321, 32'd2, w);
        issue(T_LOADC, -64'sd7, 64'sd0, 32'd3, w);
        issue(T_LOADC, 64'sd0, 64'sd65536, 32'd4, w);
        issue(T_PUSH, 64'sd1000, -64'sd1, 32'd0, w);
        issue(T_PUSH, -64'sd2000, 64'sd300, 32'd0, w);
        issue(T_PUSH, 64'sd555555, -64'sd44, 32'd0, w);
        issue(7'h33, 64'sd12345, 64'sd12345, 32'd0, w);
        model_result(er, ei);
        issue(T_COMPUTE, 64'sd0, 64'sd0, 32'd0, w);
        issue(T_PUSH, 64'sd77, 64'sd88, 32'd0, w);
        check("busy_cycles", 64'(w), 64'd6);
        check("full_valid", 64'(io_rd_valid), 64'd1);
        check("full_real", io_rd_real, er);
        check("full_imag", io_rd_imag, ei);

        // Out-of-range coefficient index is ignored.
        issue(T_LOADC, 64'sd999999, 64'sd999999, 32'd7, w);
        model_result(er, ei);
        issue(T_COMPUTE, 64'sd0, 64'sd0, 32'd0, w);
        wait_valid(n);
        check("idx7_real", io_rd_real, er);
        check("idx7_imag", io_rd_imag, ei);

        // Reset during the third MAC cycle.
        issue(T_COMPUTE, 64'sd0, 64'sd0, 32'd0, w);
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("pre_reset_busy", 64'(io_ready), 64'd0);
        reset = 1'b1;
        #1;
        check("midmac_rd_valid", 64'(io_rd_valid), 64'd0);
        check("midmac_ready", 64'(io_ready), 64'd1);
        check("midmac_rd_real", io_rd_real, 64'sd0);
        @(posedge clock); #1;
        reset = 1'b0;
        model_clear_all();
        issue(T_COMPUTE, 64'sd0, 64'sd0, 32'd0, w);
        wait_valid(n);
        check("post_reset_valid", 64'(io_rd_valid), 64'd1);
        check("post_reset_real", io_rd_real, 64'sd0);
        check("post_reset_imag", io_rd_imag, 64'sd0);

        // CLEAR empties the delay line but keeps the coefficients.
        for (int t = 0; t < 5; t++) issue(T_LOADC, 64'(t * 300 + 11), -64'(t * 50 + 3), 32'(t), w);
        for (int t = 0; t < 5; t++) issue(T_PUSH, 64'(t * 1000 - 2222), 64'(t * 77 + 5), 32'd0, w);
        issue(T_CLEAR, 64'sd0, 64'sd0, 32'd0, w);
        issue(T_COMPUTE, 64'sd0, 64'sd0, 32'd0, w);
        wait_valid(n);
        check("clear_valid", 64'(io_rd_valid), 64'd1);
        check("clear_real", io_rd_real, 64'sd0);
        check("clear_imag", io_rd_imag, 64'sd0);
        issue(T_PUSH, -64'sd40000, 64'sd25000, 32'd0, w);
        model_result(er, ei);
        issue(T_COMPUTE, 64'sd0, 64'sd0, 32'd0, w);
        wait_valid(n);
        check("coef_kept_real", io_rd_real, er);
        check("coef_kept_imag", io_rd_imag, ei);

        // 16-bit instance, FRAC=0: 32767*32767 either clamps or wraps.
        check("dw16_ready", 64'(rdy16), 64'd1);
        v16 = 1'b1; insn16 = {25'd0, T_LOADC}; rs1r16 = 16'sd32767; rs1i16 = 16'sd0; rs2_16 = 32'd0;
        @(posedge clock); #1;
        insn16 = {25'd0, T_PUSH};
        @(posedge clock); #1;
        insn16 = {25'd0, T_COMPUTE};
        @(posedge clock); #1;
        v16 = 1'b0;
        repeat (6) @(posedge clock);
        #1;
`ifdef SCIE_CFIR_SAT_EN
        exp16 = 64'sd32767;
`else
        exp16 = 64'sd1;
`endif
        check("dw16_valid", 64'(rdv16), 64'd1);
        check("dw16_real", 64'(rdr16), exp16);
        check("dw16_imag", 64'(rdi16), 64'sd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
